// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction fetch stage of the sm83 core (directly upstream of decode)
//
// Owns the program counter and issues single-byte reads on the memory bus.
// Each opcode byte is handed to decode/control through a valid/ready handshake.
// The stage tracks the CB-prefix state and fetches 1-2 immediate bytes when
// decode asks for them. It also handles branch redirects and HALT.
//
// Parameters
//   RESET_PC       PC value loaded on reset (boot ROM entry)
//
// Ports
//   clk            core clock, all state changes on the rising edge
//   rst            synchronous reset, active-high
//   mem_addr       read address (equals PC while mem_rd_req=1)
//   mem_rd_req     read request, held until mem_rd_ack
//   mem_rd_ack     read complete; mem_rd_data is valid in this cycle
//   mem_rd_data    read data
//   o_instr        opcode byte presented to decode
//   o_instr_valid  o_instr valid, held until consumed
//   i_instr_ready  consumer accepts o_instr (valid && ready = consume)
//   o_op_pc        address o_instr was fetched from
//   o_is_instr16   o_instr is the byte following a CB prefix
//   i_is_instr16   decode: the current o_instr is the CB prefix
//   i_imm_len      immediates to fetch after this opcode (0..2), taken on consume
//   o_imm          immediate: byte0 in [7:0], byte1 in [15:8] (0 when len=1)
//   o_imm_valid    o_imm complete, held until i_imm_ready
//   i_imm_ready    consumer accepts o_imm
//   i_halt         consumed opcode is HALT, taken on consume
//   i_wake         interrupt pending, leaves HALTED
//   i_redirect     load PC from i_redirect_pc and flush the stage (top priority)
//   i_redirect_pc  branch/call/ret/rst/interrupt target
//   o_halted       stage is halted
// ---------------------------------------------------------------------------
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  o_instr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [15:0] o_op_pc,
  output logic        o_is_instr16,
  input  logic        i_is_instr16,
  input  logic [1:0]  i_imm_len,
  output logic [15:0] o_imm,
  output logic        o_imm_valid,
  input  logic        i_imm_ready,
  input  logic        i_halt,
  input  logic        i_wake,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_halted
);

  typedef enum logic [2:0] {
    S_FETCH_OP,
    S_HOLD_OP,
    S_FETCH_IMM_LO,
    S_FETCH_IMM_HI,
    S_HOLD_IMM,
    S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_pc;
  logic        r_boot;
  logic [7:0]  r_instr;
  logic        r_instr_valid;
  logic [15:0] r_op_pc;
  logic        r_is_instr16;
  logic [15:0] r_imm;
  logic        r_imm_valid;
  logic [1:0]  r_imm_len;

  logic        w_fetch_state;
  logic        w_rd_req;
  logic        w_ack;
  logic        w_consume;
  logic        w_imm_take;

  // The request is held low for the single cycle following reset. An ack that
  // belongs to a read aborted by reset can still arrive in that cycle. The
  // ack is then ignored because it is gated with the request.
  assign w_fetch_state = (r_state == S_FETCH_OP) ||
                         (r_state == S_FETCH_IMM_LO) ||
                         (r_state == S_FETCH_IMM_HI);
  assign w_rd_req      = w_fetch_state && !r_boot;
  assign w_ack         = w_rd_req && mem_rd_ack;
  assign w_consume     = (r_state == S_HOLD_OP) && r_instr_valid && i_instr_ready;
  assign w_imm_take    = (r_state == S_HOLD_IMM) && r_imm_valid && i_imm_ready;

  assign mem_addr      = r_pc;
  assign mem_rd_req    = w_rd_req;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_op_pc       = r_op_pc;
  assign o_is_instr16  = r_is_instr16;
  assign o_imm         = r_imm;
  assign o_imm_valid   = r_imm_valid;
  assign o_halted      = (r_state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH_OP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH_OP: begin
        if (w_ack) begin
          w_state_nxt = S_HOLD_OP;
        end
      end
      S_HOLD_OP: begin
        if (w_consume) begin
          if (i_is_instr16) begin
            w_state_nxt = S_FETCH_OP;
          end else if (i_imm_len != 2'd0) begin
            w_state_nxt = S_FETCH_IMM_LO;
          end else if (i_halt) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_state_nxt = S_FETCH_OP;
          end
        end
      end
      S_FETCH_IMM_LO: begin
        if (w_ack) begin
          w_state_nxt = (r_imm_len == 2'd1) ? S_HOLD_IMM : S_FETCH_IMM_HI;
        end
      end
      S_FETCH_IMM_HI: begin
        if (w_ack) begin
          w_state_nxt = S_HOLD_IMM;
        end
      end
      S_HOLD_IMM: begin
        if (w_imm_take) begin
          w_state_nxt = S_FETCH_OP;
        end
      end
      S_HALTED: begin
        if (i_wake) begin
          w_state_nxt = S_FETCH_OP;
        end
      end
      default: w_state_nxt = S_FETCH_OP;
    endcase
    // A redirect overrides every other event, including a halt.
    if (i_redirect) begin
      w_state_nxt = S_FETCH_OP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_boot        <= 1'b1;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_op_pc       <= '0;
      r_is_instr16  <= 1'b0;
      r_imm         <= '0;
      r_imm_valid   <= 1'b0;
      r_imm_len     <= '0;
    end else begin
      r_boot <= 1'b0;
      if (i_redirect) begin
        // A read completing in this cycle is dropped. A consume in this cycle
        // still retires the byte, but its immediate and halt requests are lost.
        r_pc          <= i_redirect_pc;
        r_instr_valid <= 1'b0;
        r_imm_valid   <= 1'b0;
        r_is_instr16  <= 1'b0;
      end else begin
        case (r_state)
          S_FETCH_OP: begin
            if (w_ack) begin
              r_instr       <= mem_rd_data;
              r_op_pc       <= r_pc;
              r_pc          <= r_pc + 16'd1;
              r_instr_valid <= 1'b1;
            end
          end
          S_HOLD_OP: begin
            if (w_consume) begin
              r_instr_valid <= 1'b0;
              // Set when the consumed byte is the CB prefix. Cleared when the
              // consumed byte was itself presented as a CB suffix.
              r_is_instr16  <= i_is_instr16;
              if (!i_is_instr16 && (i_imm_len != 2'd0)) begin
                r_imm_len <= i_imm_len;
              end
            end
          end
          S_FETCH_IMM_LO: begin
            if (w_ack) begin
              r_imm[7:0] <= mem_rd_data;
              r_pc       <= r_pc + 16'd1;
              if (r_imm_len == 2'd1) begin
                r_imm[15:8] <= '0;
                r_imm_valid <= 1'b1;
              end
            end
          end
          S_FETCH_IMM_HI: begin
            if (w_ack) begin
              r_imm[15:8] <= mem_rd_data;
              r_pc        <= r_pc + 16'd1;
              r_imm_valid <= 1'b1;
            end
          end
          S_HOLD_IMM: begin
            if (w_imm_take) begin
              r_imm_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  localparam logic [15:0] TB_RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic [7:0]  o_instr;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [15:0] o_op_pc;
  logic        o_is_instr16;
  logic        i_is_instr16;
  logic [1:0]  i_imm_len;
  logic [15:0] o_imm;
  logic        o_imm_valid;
  logic        i_imm_ready;
  logic        i_halt;
  logic        i_wake;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        o_halted;

  fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_ack    (mem_rd_ack),
    .mem_rd_data   (mem_rd_data),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_op_pc       (o_op_pc),
    .o_is_instr16  (o_is_instr16),
    .i_is_instr16  (i_is_instr16),
    .i_imm_len     (i_imm_len),
    .o_imm         (o_imm),
    .o_imm_valid   (o_imm_valid),
    .i_imm_ready   (i_imm_ready),
    .i_halt        (i_halt),
    .i_wake        (i_wake),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_halted      (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Memory model: 64 KiB byte array with a programmable ack latency.
  logic [7:0]  mem [65536];
  logic        mem_en;
  logic        mem_rand;
  logic        mem_noise;
  int unsigned mem_lat;
  logic        force_ack;
  logic [7:0]  force_data;

  initial begin
    int unsigned lat_cnt;
    int unsigned cur_rand;
    int unsigned target;
    mem_rd_ack  = 1'b0;
    mem_rd_data = 8'h00;
    lat_cnt     = 0;
    cur_rand    = 0;
    forever begin
      @(negedge clk);
      mem_rd_ack = 1'b0;
      if (!mem_en) begin
        mem_rd_ack  = force_ack;
        mem_rd_data = force_data;
      end else if (rst || !mem_rd_req) begin
        lat_cnt = 0;
        if (mem_noise && ($urandom_range(0, 3) == 0)) begin
          mem_rd_ack  = 1'b1;
          mem_rd_data = 8'($urandom);
        end
      end else begin
        target = mem_rand ? cur_rand : mem_lat;
        if (lat_cnt >= target) begin
          mem_rd_ack  = 1'b1;
          mem_rd_data = mem[mem_addr];
          lat_cnt     = 0;
          cur_rand    = $urandom_range(0, 3);
        end else begin
          lat_cnt = lat_cnt + 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // 0: o_instr_valid, 1: o_imm_valid, 2: mem_rd_req
  task automatic wait_for(input int which, input string name);
    logic hit;
    for (int i = 0; i < 60; i++) begin
      hit = (which == 0) ? o_instr_valid : (which == 1) ? o_imm_valid : mem_rd_req;
      if (hit) return;
      cyc();
    end
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic clear_inputs();
    i_instr_ready = 1'b0;
    i_is_instr16  = 1'b0;
    i_imm_len     = 2'd0;
    i_imm_ready   = 1'b0;
    i_halt        = 1'b0;
    i_wake        = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
  endtask

  // Leaves the bench sampling in the first cycle after the last reset edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    cyc();
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    cyc();
    i_redirect    = 1'b0;
  endtask

  // Transaction-level reference: expected next fetch address, which item is
  // currently presented, and how many immediate bytes are still outstanding.
  task automatic run_random(input int ncyc);
    logic [15:0] m_pc, m_op_pc, m_imm;
    logic [7:0]  m_op;
    logic        m_boot, m_halted, m_ipend, m_vpend, m_cb, exp_req;
    int          m_left, m_nimm;
    m_pc = TB_RESET_PC; m_op_pc = '0; m_imm = '0; m_op = '0;
    m_boot = 1'b1; m_halted = 1'b0; m_ipend = 1'b0; m_vpend = 1'b0; m_cb = 1'b0;
    m_left = 0; m_nimm = 0;
    for (int c = 0; c < ncyc; c++) begin
      exp_req = !m_boot && !m_halted && !m_ipend && !m_vpend;
      chk("rnd_req", mem_rd_req, exp_req);
      if (exp_req) chk("rnd_addr", mem_addr, m_pc);
      chk("rnd_ivalid", o_instr_valid, m_ipend);
      if (m_ipend) begin
        chk("rnd_instr", o_instr, m_op);
        chk("rnd_op_pc", o_op_pc, m_op_pc);
        chk("rnd_is16", o_is_instr16, m_cb);
      end
      chk("rnd_vvalid", o_imm_valid, m_vpend);
      if (m_vpend) chk("rnd_imm", o_imm, m_imm);
      chk("rnd_halted", o_halted, m_halted);

      i_instr_ready = ($urandom_range(0, 2) != 0);
      i_is_instr16  = ($urandom_range(0, 5) == 0) && !m_cb;
      i_imm_len     = 2'($urandom_range(0, 2));
      i_halt        = ($urandom_range(0, 5) == 0);
      i_imm_ready   = ($urandom_range(0, 1) == 1);
      i_wake        = ($urandom_range(0, 3) == 0);
      i_redirect    = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       i_redirect_pc = 16'hFFFE;
        1:       i_redirect_pc = 16'hFFFF;
        default: i_redirect_pc = 16'($urandom);
      endcase

      if (i_redirect) begin
        m_pc = i_redirect_pc; m_ipend = 1'b0; m_vpend = 1'b0; m_cb = 1'b0;
        m_halted = 1'b0; m_left = 0;
      end else if (m_halted) begin
        if (i_wake) m_halted = 1'b0;
      end else if (m_ipend) begin
        if (i_instr_ready) begin
          m_ipend = 1'b0;
          m_cb    = i_is_instr16;
          if (!i_is_instr16) begin
            if (i_imm_len != 2'd0) begin
              m_left = int'(i_imm_len); m_nimm = 0; m_imm = '0;
            end else if (i_halt) begin
              m_halted = 1'b1;
            end
          end
        end
      end else if (m_vpend) begin
        if (i_imm_ready) m_vpend = 1'b0;
      end else if (exp_req && mem_rd_ack) begin
        if (m_left == 0) begin
          m_op = mem_rd_data; m_op_pc = m_pc; m_ipend = 1'b1;
        end else begin
          if (m_nimm == 0) m_imm[7:0] = mem_rd_data;
          else             m_imm[15:8] = mem_rd_data;
          m_nimm++;
          m_left--;
          if (m_left == 0) m_vpend = 1'b1;
        end
        m_pc = m_pc + 16'd1;
      end
      m_boot = 1'b0;
      cyc();
    end
    clear_inputs();
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b0, b1, b2;
    logic [1:0]  len;
    logic [7:0]  exp_instr;
    logic [15:0] exp_imm;
    logic [15:0] exp_next;
  } vec_t;

  initial begin
    vec_t        vec [6];
    logic [15:0] a;
    checks = 0; failures = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem_en = 1'b1; mem_rand = 1'b0; mem_noise = 1'b0; mem_lat = 0;
    force_ack = 1'b0; force_data = 8'h00;

    vec[0] = '{16'h0400, 8'hAF, 8'h00, 8'h00, 2'd0, 8'hAF, 16'h0000, 16'h0401};
    vec[1] = '{16'h0500, 8'h06, 8'h5A, 8'h00, 2'd1, 8'h06, 16'h005A, 16'h0502};
    vec[2] = '{16'h0600, 8'h01, 8'hCD, 8'hAB, 2'd2, 8'h01, 16'hABCD, 16'h0603};
    vec[3] = '{16'hFFFE, 8'h21, 8'h78, 8'h56, 2'd2, 8'h21, 16'h5678, 16'h0001};
    vec[4] = '{16'hFFFF, 8'h3E, 8'h99, 8'h00, 2'd1, 8'h3E, 16'h0099, 16'h0001};
    vec[5] = '{16'h7FFF, 8'h18, 8'hFE, 8'h00, 2'd1, 8'h18, 16'h00FE, 16'h8001};

    // Reset state and zero-wait opcode stream
    do_reset();
    chk("rst_ivalid", o_instr_valid, 1'b0);
    chk("rst_vvalid", o_imm_valid, 1'b0);
    chk("rst_halted", o_halted, 1'b0);
    chk("rst_is16", o_is_instr16, 1'b0);
    chk("rst_req", mem_rd_req, 1'b0);
    chk("rst_addr", mem_addr, TB_RESET_PC);
    chk("rst_instr", o_instr, 8'h00);
    chk("rst_op_pc", o_op_pc, 16'h0000);
    chk("rst_imm", o_imm, 16'h0000);
    i_instr_ready = 1'b1;
    cyc();
    chk("t1_req0", mem_rd_req, 1'b1);
    chk("t1_addr0", mem_addr, 16'h0000);
    cyc();
    chk("t1_valid0", o_instr_valid, 1'b1);
    chk("t1_instr0", o_instr, 8'h00);
    chk("t1_op_pc0", o_op_pc, 16'h0000);
    chk("t1_noreq", mem_rd_req, 1'b0);
    cyc();
    chk("t1_req1", mem_rd_req, 1'b1);
    chk("t1_addr1", mem_addr, 16'h0001);
    chk("t1_valid_gap", o_instr_valid, 1'b0);
    cyc();
    chk("t1_valid1", o_instr_valid, 1'b1);
    chk("t1_op_pc1", o_op_pc, 16'h0001);
    i_instr_ready = 1'b0;

    // LD A,d8 with 3-cycle memory latency
    mem[16'h0100] = 8'h3E; mem[16'h0101] = 8'h42; mem_lat = 3;
    redirect_to(16'h0100);
    wait_for(0, "t2_instr_wait");
    chk("t2_instr", o_instr, 8'h3E);
    chk("t2_op_pc", o_op_pc, 16'h0100);
    i_instr_ready = 1'b1; i_imm_len = 2'd1;
    cyc();
    i_instr_ready = 1'b0; i_imm_len = 2'd0;
    chk("t2_imm_addr", mem_addr, 16'h0101);
    wait_for(1, "t2_imm_wait");
    chk("t2_imm", o_imm, 16'h0042);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_imm_hold", o_imm_valid, 1'b1);
      chk("t2_hold_noreq", mem_rd_req, 1'b0);
    end
    i_imm_ready = 1'b1;
    cyc();
    i_imm_ready = 1'b0;
    chk("t2_imm_drop", o_imm_valid, 1'b0);
    chk("t2_next_req", mem_rd_req, 1'b1);
    chk("t2_next_addr", mem_addr, 16'h0102);

    // CB prefix
    mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h11; mem_lat = 0;
    redirect_to(16'h0200);
    wait_for(0, "t3_cb_wait");
    chk("t3_cb", o_instr, 8'hCB);
    chk("t3_cb_flag", o_is_instr16, 1'b0);
    i_instr_ready = 1'b1; i_is_instr16 = 1'b1;
    cyc();
    i_instr_ready = 1'b0; i_is_instr16 = 1'b0;
    wait_for(0, "t3_sfx_wait");
    chk("t3_sfx", o_instr, 8'h11);
    chk("t3_sfx_flag", o_is_instr16, 1'b1);
    chk("t3_sfx_pc", o_op_pc, 16'h0201);
    i_instr_ready = 1'b1;
    cyc();
    i_instr_ready = 1'b0;
    chk("t3_flag_clr", o_is_instr16, 1'b0);

    // JP a16 with redirect in the immediate hand-off cycle
    mem[16'h0300] = 8'hC3; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12; mem_lat = 5;
    redirect_to(16'h0300);
    wait_for(0, "t4_instr_wait");
    chk("t4_instr", o_instr, 8'hC3);
    i_instr_ready = 1'b1; i_imm_len = 2'd2;
    cyc();
    i_instr_ready = 1'b0; i_imm_len = 2'd0;
    wait_for(1, "t4_imm_wait");
    chk("t4_imm", o_imm, 16'h1234);
    i_imm_ready = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 16'h1234;
    cyc();
    i_imm_ready = 1'b0; i_redirect = 1'b0;
    chk("t4_vvalid", o_imm_valid, 1'b0);
    chk("t4_imm_keep", o_imm, 16'h1234);
    chk("t4_req", mem_rd_req, 1'b1);
    chk("t4_addr", mem_addr, 16'h1234);

    // Redirect coinciding with an ack: data must be dropped
    mem_en = 1'b0; force_ack = 1'b1; force_data = 8'hAA;
    cyc();
    force_ack = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 16'h8000;
    cyc();
    i_redirect = 1'b0;
    chk("t5_ivalid", o_instr_valid, 1'b0);
    chk("t5_instr_keep", o_instr, 8'hC3);
    chk("t5_req", mem_rd_req, 1'b1);
    chk("t5_addr", mem_addr, 16'h8000);
    cyc();
    chk("t5_ivalid2", o_instr_valid, 1'b0);
    mem_en = 1'b1; mem_lat = 1;

    // HALT at FFFF, wake wraps to 0000
    mem[16'hFFFF] = 8'h76;
    redirect_to(16'hFFFF);
    wait_for(0, "t6_instr_wait");
    chk("t6_instr", o_instr, 8'h76);
    chk("t6_op_pc", o_op_pc, 16'hFFFF);
    i_instr_ready = 1'b1; i_halt = 1'b1;
    cyc();
    i_instr_ready = 1'b0; i_halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_halted", o_halted, 1'b1);
      chk("t6_noreq", mem_rd_req, 1'b0);
      cyc();
    end
    i_wake = 1'b1;
    cyc();
    i_wake = 1'b0;
    chk("t6_wake", o_halted, 1'b0);
    chk("t6_req", mem_rd_req, 1'b1);
    chk("t6_addr", mem_addr, 16'h0000);

    // Table of single instructions including wrap cases
    mem_lat = 0;
    for (int v = 0; v < 6; v++) begin
      a = vec[v].pc;  mem[a] = vec[v].b0;
      a = a + 16'd1;  mem[a] = vec[v].b1;
      a = a + 16'd1;  mem[a] = vec[v].b2;
      redirect_to(vec[v].pc);
      wait_for(0, "tbl_instr_wait");
      chk("tbl_instr", o_instr, vec[v].exp_instr);
      chk("tbl_op_pc", o_op_pc, vec[v].pc);
      i_instr_ready = 1'b1; i_imm_len = vec[v].len;
      cyc();
      i_instr_ready = 1'b0; i_imm_len = 2'd0;
      if (vec[v].len != 2'd0) begin
        wait_for(1, "tbl_imm_wait");
        chk("tbl_imm", o_imm, vec[v].exp_imm);
        i_imm_ready = 1'b1;
        cyc();
        i_imm_ready = 1'b0;
      end
      wait_for(2, "tbl_next_wait");
      chk("tbl_next", mem_addr, vec[v].exp_next);
    end

    // Randomized segments against the transaction model
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem_rand = 1'b1; mem_noise = 1'b1;
    for (int s = 0; s < 3; s++) begin
      do_reset();
      run_random(1500);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
